mod6_seq_checker: RTL and testbench

MOD6_SEQ_CHECKER -- requirements
Module: mod6_seq_checker

---
 rtl/mod6_pkg.sv | 18 +
 rtl/mod6_sat_cnt.sv | 22 ++
 rtl/mod6_seq_checker.sv | 140 ++++++++++++++
 tb/tb_mod6_seq_checker.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod6_pkg.sv
// Shared types, constants and the mod-6 successor function for the sequence checker.
package mod6_pkg;

    localparam logic [2:0] MOD6_MAX = 3'd5;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_VERIFY  = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_SUSPECT = 2'd3
    } state_e;

    function automatic logic [2:0] next(input logic [2:0] v);
        return (v == MOD6_MAX) ? 3'd0 : v + 3'd1;
    endfunction

endpackage

// File: rtl/mod6_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module mod6_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mod6_seq_checker.sv
// Mod-6 count stream checker: hunts, verifies and locks onto a 0..5 sequence, flagging errors and wraps.
// Defining MOD6_CHK_ERRCNT_EN adds the err_clr input and the saturating err_cnt output.
module mod6_seq_checker
    import mod6_pkg::*;
#(
    parameter int unsigned LOCK_THRESH   = 3,
    parameter int unsigned UNLOCK_THRESH = 2,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [2:0]           in_count,
    output logic                 locked,
    output logic [2:0]           expected,
    output logic                 err_pulse,
    output logic                 wrap_pulse
`ifdef MOD6_CHK_ERRCNT_EN
    ,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    if ((LOCK_THRESH < 1) || (LOCK_THRESH > 7)) begin : g_bad_lock
        $error("LOCK_THRESH must be in 1..7");
    end
    if ((UNLOCK_THRESH < 1) || (UNLOCK_THRESH > 7)) begin : g_bad_unlock
        $error("UNLOCK_THRESH must be in 1..7");
    end
    if (ERR_CNT_W < 1) begin : g_bad_width
        $error("ERR_CNT_W must be at least 1");
    end

    state_e           state, state_n;
    logic [CNT_W-1:0] good, good_n, good_inc;
    logic [CNT_W-1:0] bad, bad_n, bad_inc;
    logic [2:0]       exp_n;
    logic             legal, match;
    logic             err_c, wrap_c;

    // Next-state and pulse decode; an idle cycle leaves everything as is.
    always_comb begin
        state_n  = state;
        good_n   = good;
        bad_n    = bad;
        exp_n    = expected;
        err_c    = 1'b0;
        wrap_c   = 1'b0;
        legal    = (in_count <= MOD6_MAX);
        match    = legal && (in_count == expected);
        good_inc = (good == 3'd7) ? good : good + 3'd1;
        bad_inc  = (bad == 3'd7) ? bad : bad + 3'd1;

        if (in_valid) begin
            case (state)
                ST_HUNT: begin
                    if (legal) begin
                        exp_n   = next(in_count);
                        good_n  = 3'd1;
                        state_n = (LOCK_THRESH <= 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (!legal) begin
                        good_n  = '0;
                        state_n = ST_HUNT;
                    end else if (match) begin
                        exp_n  = next(in_count);
                        good_n = good_inc;
                        if (32'(good_inc) >= LOCK_THRESH) begin
                            state_n = ST_LOCKED;
                        end
                    end else begin
                        exp_n  = next(in_count);
                        good_n = 3'd1;
                    end
                end
                ST_LOCKED, ST_SUSPECT: begin
                    if (match) begin
                        exp_n   = next(in_count);
                        bad_n   = '0;
                        wrap_c  = (in_count == 3'd0);
                        state_n = ST_LOCKED;
                    end else begin
                        // Flywheel: keep predicting as if the stream had advanced.
                        err_c = 1'b1;
                        exp_n = next(expected);
                        bad_n = (state == ST_LOCKED) ? 3'd1 : bad_inc;
                        if (32'(bad_n) >= UNLOCK_THRESH) begin
                            good_n  = '0;
                            bad_n   = '0;
                            state_n = ST_HUNT;
                        end else begin
                            state_n = ST_SUSPECT;
                        end
                    end
                end
                default: begin
                    good_n  = '0;
                    bad_n   = '0;
                    state_n = ST_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_HUNT;
            good       <= '0;
            bad        <= '0;
            expected   <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            good       <= good_n;
            bad        <= bad_n;
            expected   <= exp_n;
            locked     <= (state_n == ST_LOCKED) || (state_n == ST_SUSPECT);
            err_pulse  <= err_c;
            wrap_pulse <= wrap_c;
        end
    end

`ifdef MOD6_CHK_ERRCNT_EN
    mod6_sat_cnt #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (err_c),
        .clr  (err_clr),
        .count(err_cnt)
    );
`endif

endmodule

// File: tb/tb_mod6_seq_checker.sv
// Randomized and directed bench for mod6_seq_checker against a behavioural stream-tracking model.
module tb_mod6_seq_checker;

    localparam int LOCK   = 3;
    localparam int UNLOCK = 2;
    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2, M_SUSPECT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_count = 3'd0;
    logic       locked, err_pulse, wrap_pulse;
    logic [2:0] expected;
`ifdef MOD6_CHK_ERRCNT_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt;
    logic       locked2, err_pulse2, wrap_pulse2;
    logic [2:0] expected2;
    logic [1:0] err_cnt2;
`endif

    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // Model of the stream tracker: mode, run lengths, prediction, pulses, error counts.
    int m_mode = M_HUNT, m_good = 0, m_bad = 0, m_exp = 0;
    int m_err = 0, m_wrap = 0, m_cnt8 = 0, m_cnt2 = 0;

    always #5 clk = ~clk;

    mod6_seq_checker #(
        .LOCK_THRESH(LOCK), .UNLOCK_THRESH(UNLOCK), .ERR_CNT_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count),
        .locked(locked), .expected(expected), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse)
`ifdef MOD6_CHK_ERRCNT_EN
        , .err_clr(err_clr), .err_cnt(err_cnt)
`endif
    );

`ifdef MOD6_CHK_ERRCNT_EN
    mod6_seq_checker #(
        .LOCK_THRESH(LOCK), .UNLOCK_THRESH(UNLOCK), .ERR_CNT_W(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count),
        .locked(locked2), .expected(expected2), .err_pulse(err_pulse2), .wrap_pulse(wrap_pulse2),
        .err_clr(err_clr), .err_cnt(err_cnt2)
    );
`endif

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_HUNT; m_good = 0; m_bad = 0; m_exp = 0;
        m_err = 0; m_wrap = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic model_step(input bit valid, input int v, input bit clr);
        bit legal, hit;
        m_err = 0;
        m_wrap = 0;
        legal = (v < 6);
        hit = legal && (v == m_exp);
        if (valid) begin
            if (m_mode == M_HUNT) begin
                if (legal) begin
                    m_exp = (v + 1) % 6;
                    m_good = 1;
                    m_mode = (m_good >= LOCK) ? M_LOCKED : M_VERIFY;
                end
            end else if (m_mode == M_VERIFY) begin
                if (!legal) m_mode = M_HUNT;
                else if (hit) begin
                    m_good++;
                    m_exp = (v + 1) % 6;
                    if (m_good >= LOCK) m_mode = M_LOCKED;
                end else begin
                    m_good = 1;
                    m_exp = (v + 1) % 6;
                end
            end else begin
                if (hit) begin
                    m_bad = 0;
                    m_mode = M_LOCKED;
                    m_exp = (v + 1) % 6;
                    m_wrap = (v == 0) ? 1 : 0;
                end else begin
                    m_err = 1;
                    m_exp = (m_exp + 1) % 6;
                    m_bad++;
                    if (m_bad >= UNLOCK) begin
                        m_mode = M_HUNT;
                        m_bad = 0;
                    end else m_mode = M_SUSPECT;
                end
            end
        end
        if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (m_err != 0) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    // One sample: drive at the falling edge, model the rising edge, return at the next falling edge.
    task automatic cyc(input bit valid, input int v, input bit clr);
        in_valid = valid;
        in_count = 3'(v);
`ifdef MOD6_CHK_ERRCNT_EN
        err_clr = clr;
`endif
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_step(valid, v, clr);
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_expected"}, int'(expected), 0);
        chk({tag, "_err_pulse"}, int'(err_pulse), 0);
        chk({tag, "_wrap_pulse"}, int'(wrap_pulse), 0);
`ifdef MOD6_CHK_ERRCNT_EN
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_err_cnt2"}, int'(err_cnt2), 0);
`endif
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_locked", int'(locked), (m_mode >= M_LOCKED) ? 1 : 0);
            chk("cyc_expected", int'(expected), m_exp);
            chk("cyc_err_pulse", int'(err_pulse), m_err);
            chk("cyc_wrap_pulse", int'(wrap_pulse), m_wrap);
`ifdef MOD6_CHK_ERRCNT_EN
            chk("cyc_err_cnt", int'(err_cnt), m_cnt8);
            chk("cyc_err_cnt2", int'(err_cnt2), m_cnt2);
            chk("cyc_locked2", int'(locked2), (m_mode >= M_LOCKED) ? 1 : 0);
`endif
        end
    end

    initial begin
        int seq_a[4];
        int v;
        bit vld, clr;

        // Power-on reset.
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // Acquire lock on 2,3,4,5.
        seq_a = '{2, 3, 4, 5};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, seq_a[i], 1'b0);
            if (i == 1) chk("acq_unlocked_after_3", int'(locked), 0);
        end
        chk("acq_locked", int'(locked), 1);
        chk("acq_expected", int'(expected), 0);

        // Wrap 5->0.
        cyc(1'b1, 0, 1'b0);
        chk("wrap_pulse_hi", int'(wrap_pulse), 1);
        chk("wrap_err_lo", int'(err_pulse), 0);
        cyc(1'b0, 0, 1'b0);
        chk("wrap_pulse_one_cycle", int'(wrap_pulse), 0);
        cyc(1'b1, 1, 1'b0);
        cyc(1'b1, 2, 1'b0);
        chk("pre_inject_expected", int'(expected), 3);

        // Illegal value while locked, then the flywheel-matching 4.
        cyc(1'b1, 6, 1'b0);
        chk("inject_err", int'(err_pulse), 1);
        chk("inject_still_locked", int'(locked), 1);
        chk("inject_flywheel", int'(expected), 4);
`ifdef MOD6_CHK_ERRCNT_EN
        chk("inject_err_cnt", int'(err_cnt), 1);
`endif
        cyc(1'b1, 4, 1'b0);
        chk("recover_err_lo", int'(err_pulse), 0);
        chk("recover_locked", int'(locked), 1);
        chk("recover_expected", int'(expected), 5);

        // Two consecutive mismatches drop lock; next 1 enters verify.
        cyc(1'b1, 1, 1'b0);
        chk("miss1_err", int'(err_pulse), 1);
        cyc(1'b1, 3, 1'b0);
        chk("miss2_err", int'(err_pulse), 1);
        chk("miss2_unlocked", int'(locked), 0);
        cyc(1'b1, 1, 1'b0);
        chk("hunt_verify_expected", int'(expected), 2);
        chk("hunt_verify_err_lo", int'(err_pulse), 0);
        chk("hunt_verify_unlocked", int'(locked), 0);

        // Error counter: clear, relock, four errors saturate a 2-bit count, fifth with clear zeroes it.
        cyc(1'b0, 0, 1'b1);
        cyc(1'b1, 2, 1'b0);
        cyc(1'b1, 3, 1'b0);
        chk("relock_for_cnt", int'(locked), 1);
        cyc(1'b1, 7, 1'b0); cyc(1'b1, 5, 1'b0);
        cyc(1'b1, 7, 1'b0); cyc(1'b1, 1, 1'b0);
        cyc(1'b1, 7, 1'b0); cyc(1'b1, 3, 1'b0);
        cyc(1'b1, 7, 1'b0);
`ifdef MOD6_CHK_ERRCNT_EN
        chk("cnt2_saturated", int'(err_cnt2), 3);
        chk("cnt8_four", int'(err_cnt), 4);
`endif
        cyc(1'b1, 5, 1'b0);
        cyc(1'b1, 7, 1'b1);
        chk("fifth_err_pulse", int'(err_pulse), 1);
`ifdef MOD6_CHK_ERRCNT_EN
        chk("cnt2_cleared", int'(err_cnt2), 0);
        chk("cnt8_cleared", int'(err_cnt), 0);
`endif
        chk("locked_before_reset", int'(locked), 1);

        // Asynchronous reset mid-cycle while locked and in_valid toggling.
        in_valid = 1'b1;
        in_count = 3'd1;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async");
        model_reset();
        cyc(1'b0, 2, 1'b0);
        cyc(1'b1, 3, 1'b0);
        rst_n = 1'b1;
        cyc(1'b1, 4, 1'b0);
        cyc(1'b1, 5, 1'b0);
        chk("relock_not_yet", int'(locked), 0);
        cyc(1'b1, 0, 1'b0);
        chk("relock_third_match", int'(locked), 1);
        chk("relock_expected", int'(expected), 1);

        // Randomized stream: mostly on-prediction, with glitches, idles, clears and resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                #2 rst_n = 1'b0;
                #1 chk_reset_outputs("rand_async");
                model_reset();
                cyc(1'b1, int'($urandom_range(0, 7)), 1'b0);
                rst_n = 1'b1;
            end
            vld = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 7));
            clr = ($urandom_range(0, 99) == 0);
            cyc(vld, v, clr);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
